// File: rtl/lf_meas_sequencer.sv
// lf_meas_sequencer
// Measurement sequencer for the auto-scaled low-frequency counter. It runs the
// microsecond period counter through repeated start/done handshakes, sums
// 2^N_AVG_LOG2 period samples and publishes their truncated average. A sample
// that never arrives within TIMEOUT_CYC cycles aborts the block. Single-shot
// and continuous operation are supported.
//
// Ports
//   clk           system clock (50 MHz), rising edge
//   reset         asynchronous, active-low
//   go            start request, sampled in IDLE only
//   cont          1 = continuous mode, 0 = single-shot
//   cnt_ready     period counter is idle
//   cnt_done_tick one-cycle pulse: period counter finished a measurement
//   cnt_prd       counter result in us, valid with cnt_done_tick
//   cnt_start     start pulse to the period counter
//   cnt_reset     synchronous active-high reset to the period counter
//   busy          sequencer is not in IDLE
//   valid         one-cycle pulse: prd_avg has just been updated
//   prd_avg       averaged period in us, held until the next valid
//   timeout       one-cycle pulse on a measurement abort
//   too_fast      1 if any sample of the last published block was 0
module lf_meas_sequencer #(
  parameter int unsigned N_AVG_LOG2  = 2,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        cont,
  input  logic        cnt_ready,
  input  logic        cnt_done_tick,
  input  logic [19:0] cnt_prd,
  output logic        cnt_start,
  output logic        cnt_reset,
  output logic        busy,
  output logic        valid,
  output logic [19:0] prd_avg,
  output logic        timeout,
  output logic        too_fast
);

  // The accumulator holds 2^N samples of 20 bits, so it cannot overflow.
  localparam int unsigned ACC_W = 20 + N_AVG_LOG2;
  // One spare bit keeps the sample index a legal vector even when N = 0.
  localparam int unsigned K_W   = N_AVG_LOG2 + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [K_W-1:0]   K_LAST   = K_W'((1 << N_AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_OUT,
    S_TMO
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [K_W-1:0]   k;
  logic             tf_acc;
  logic             sample_zero;
  logic [TMO_W-1:0] tmo_cnt;

  // Running sum including the sample on cnt_prd this cycle; the average is
  // taken from this so the final sample is included without an extra cycle.
  assign acc_sum     = acc + ACC_W'(cnt_prd);
  assign sample_zero = (cnt_prd == '0);

  // The start pulse follows cnt_ready while armed, so the counter is
  // re-launched in the same cycle it reports idle.
  assign cnt_start   = (state == S_ARM) && cnt_ready;

  // NOTE: every register here, state and datapath alike, is updated with
  // non-blocking assignments so all branches read the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      k         <= '0;
      tf_acc    <= 1'b0;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      cnt_reset <= 1'b1;
      prd_avg   <= '0;
      too_fast  <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised on the edge that enters
      // the state they belong to, which makes them registered and one cycle.
      valid     <= 1'b0;
      timeout   <= 1'b0;
      cnt_reset <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (go) begin
            state  <= S_ARM;
            busy   <= 1'b1;
            acc    <= '0;
            k      <= '0;
            tf_acc <= 1'b0;
          end
        end

        S_ARM: begin
          if (cnt_ready) begin
            state   <= S_WAIT;
            tmo_cnt <= '0;
          end
        end

        S_WAIT: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          // A sample arriving on the terminal-count cycle takes priority.
          if (cnt_done_tick) begin
            acc    <= acc_sum;
            k      <= k + K_W'(1);
            tf_acc <= tf_acc | sample_zero;
            if (k == K_LAST) begin
              state    <= S_OUT;
              valid    <= 1'b1;
              prd_avg  <= acc_sum[ACC_W-1:N_AVG_LOG2];
              too_fast <= tf_acc | sample_zero;
            end else begin
              state <= S_ARM;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= S_TMO;
            timeout   <= 1'b1;
            cnt_reset <= 1'b1;
          end
        end

        S_OUT, S_TMO: begin
          acc    <= '0;
          k      <= '0;
          tf_acc <= 1'b0;
          state  <= cont ? S_ARM : S_IDLE;
          busy   <= cont;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
